// File: rtl/mdu_seq.sv
// mdu_seq: iterative multiply/divide sequencer with architectural HI/LO.
// Shift-add multiply and restoring divide run on magnitudes, one bit per
// cycle. A single FIX cycle then applies the sign correction and writes HI/LO.
// Optional build macro MDU_EARLY_OUT_EN lets an operation finish early:
// - a multiply stops once the remaining multiplier bits are zero;
// - a divide by zero goes straight to FIX.
module mdu_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       MDCode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [WIDTH:0]     acc_reg, acc_next;     // product upper half / remainder
  logic [WIDTH-1:0]   mq_reg, mq_next;       // multiplier / dividend-quotient
  logic [WIDTH-1:0]   opd_reg, opd_next;     // multiplicand / divisor magnitude
  logic               sign_a_reg, sign_a_next;
  logic               sign_b_reg, sign_b_next;
  logic               is_div_reg, is_div_next;
  logic               is_signed_reg, is_signed_next;
  logic [WIDTH-1:0]   hi_reg, hi_next;
  logic [WIDTH-1:0]   lo_reg, lo_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;

  // Operand capture: magnitudes for signed ops, raw bits for unsigned ops.
  logic               start_signed, start_div;
  logic [WIDTH-1:0]   a_cap, b_cap;
  assign start_signed = (MDCode == OP_MULT) || (MDCode == OP_DIV);
  assign start_div    = (MDCode == OP_DIV)  || (MDCode == OP_DIVU);
  assign a_cap = (start_signed && A[WIDTH-1]) ? ('0 - A) : A;
  assign b_cap = (start_signed && B[WIDTH-1]) ? ('0 - B) : B;

  // Multiply step: conditional add into the upper half, then shift right with carry.
  logic [WIDTH:0]     sum_mul;
  logic [WIDTH:0]     mul_acc_sh;
  logic [WIDTH-1:0]   mul_mq_sh;
  assign sum_mul    = acc_reg + (mq_reg[0] ? {1'b0, opd_reg} : '0);
  assign mul_acc_sh = {1'b0, sum_mul[WIDTH:1]};
  assign mul_mq_sh  = {sum_mul[0], mq_reg[WIDTH-1:1]};

  // Divide step: shift {rem, quo} left, trial-subtract the divisor.
  logic [WIDTH:0]     rem_sh, trial;
  logic               div_ok;
  assign rem_sh = {acc_reg[WIDTH-1:0], mq_reg[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, opd_reg};
  assign div_ok = (rem_sh >= {1'b0, opd_reg});

  logic cnt_last, mul_last, calc_last;
  assign cnt_last = (cnt_reg == CNT_W'(WIDTH - 1));

  logic [2*WIDTH-1:0] prod_raw;
`ifdef MDU_EARLY_OUT_EN
  // Bits of the multiplier still unprocessed after this cycle's shift.
  logic [CNT_W:0]     steps;
  logic [WIDTH-1:0]   low_mask;
  assign steps    = {1'b0, cnt_reg} + (CNT_W+1)'(1);
  assign low_mask = {WIDTH{1'b1}} >> steps;
  assign mul_last = cnt_last || ((mul_mq_sh & low_mask) == '0);
  // An early exit leaves the product short of its final alignment.
  assign prod_raw = {acc_reg[WIDTH-1:0], mq_reg} >> (CNT_W'(WIDTH - 1) - cnt_reg);
`else
  assign mul_last = cnt_last;
  assign prod_raw = {acc_reg[WIDTH-1:0], mq_reg};
`endif
  assign calc_last = is_div_reg ? cnt_last : mul_last;

  // Sign correction; a zero divisor keeps the all-ones quotient.
  logic               neg_res;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  assign neg_res  = is_signed_reg && (sign_a_reg ^ sign_b_reg);
  assign prod_fix = neg_res ? ('0 - prod_raw) : prod_raw;
  assign quo_fix  = (neg_res && (opd_reg != '0)) ? ('0 - mq_reg) : mq_reg;
  assign rem_fix  = (is_signed_reg && sign_a_reg) ? ('0 - acc_reg[WIDTH-1:0])
                                                  : acc_reg[WIDTH-1:0];

  // Next-state and datapath updates for the IDLE/CALC/FIX sequencer.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    acc_next       = acc_reg;
    mq_next        = mq_reg;
    opd_next       = opd_reg;
    sign_a_next    = sign_a_reg;
    sign_b_next    = sign_b_reg;
    is_div_next    = is_div_reg;
    is_signed_next = is_signed_reg;
    hi_next        = hi_reg;
    lo_next        = lo_reg;
    done_next      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start && !flush) begin
          case (MDCode)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              is_signed_next = start_signed;
              is_div_next    = start_div;
              sign_a_next    = A[WIDTH-1];
              sign_b_next    = B[WIDTH-1];
              acc_next       = '0;
              cnt_next       = '0;
              state_next     = CALC;
              if (start_div) begin
                opd_next = b_cap;
                mq_next  = a_cap;
              end else begin
                opd_next = a_cap;
                mq_next  = b_cap;
              end
`ifdef MDU_EARLY_OUT_EN
              if (start_div && (b_cap == '0)) begin
                acc_next   = {1'b0, a_cap};
                mq_next    = '1;
                state_next = FIX;
              end
`endif
            end
            OP_MTHI: begin
              hi_next   = A;
              done_next = 1'b1;
            end
            OP_MTLO: begin
              lo_next   = A;
              done_next = 1'b1;
            end
            default: ;
          endcase
        end
      end
      CALC: begin
        if (flush) begin
          state_next = IDLE;
        end else begin
          if (is_div_reg) begin
            acc_next = div_ok ? trial : rem_sh;
            mq_next  = {mq_reg[WIDTH-2:0], div_ok};
          end else begin
            acc_next = mul_acc_sh;
            mq_next  = mul_mq_sh;
          end
          if (calc_last) state_next = FIX;
          else           cnt_next   = cnt_reg + CNT_W'(1);
        end
      end
      FIX: begin
        state_next = IDLE;
        if (!flush) begin
          if (is_div_reg) begin
            lo_next = quo_fix;
            hi_next = rem_fix;
          end else begin
            {hi_next, lo_next} = prod_fix;
          end
          done_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy_next = (state_next != IDLE);

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      acc_reg       <= '0;
      mq_reg        <= '0;
      opd_reg       <= '0;
      sign_a_reg    <= 1'b0;
      sign_b_reg    <= 1'b0;
      is_div_reg    <= 1'b0;
      is_signed_reg <= 1'b0;
      hi_reg        <= '0;
      lo_reg        <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      acc_reg       <= acc_next;
      mq_reg        <= mq_next;
      opd_reg       <= opd_next;
      sign_a_reg    <= sign_a_next;
      sign_b_reg    <= sign_b_next;
      is_div_reg    <= is_div_next;
      is_signed_reg <= is_signed_next;
      hi_reg        <= hi_next;
      lo_reg        <= lo_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign HI   = hi_reg;
  assign LO   = lo_reg;

endmodule
